// File: rtl/led_scan.sv
// Time-multiplexed 7-segment scanner: advances one digit per led_clk rising edge, latching inputs once per frame.
// Optional leading-zero blanking is compiled in when SEG_LZB_EN is defined.
module led_scan #(
  parameter int NUM_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    led_clk,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   en_in,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int IDX_W    = $clog2(NUM_DIGITS);
  localparam int LAST_IDX = NUM_DIGITS - 1;

  logic                    led_clk_q;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] data_s_q;
  logic [NUM_DIGITS-1:0]   dp_s_q, en_s_q;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    frame_done_q;

  logic                    tick, wrap;
  logic [4*NUM_DIGITS-1:0] data_shift;
  logic [3:0]              nib;
  logic [NUM_DIGITS-1:0]   onehot;
  logic                    visible;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Edge detect and scan index: a held-high led_clk yields one tick only.
  assign tick = led_clk & ~led_clk_q;
  assign wrap = tick && (idx_q == IDX_W'(LAST_IDX));

  always_comb begin
    idx_d = idx_q;
    if (tick) idx_d = wrap ? '0 : idx_q + IDX_W'(1);
  end

`ifdef SEG_LZB_EN
  logic [IDX_W-1:0] msd_idx;
  always_comb begin
    msd_idx = '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (data_s_q[4*k +: 4] != 4'h0) msd_idx = IDX_W'(k);
  end
`endif

  // Pin decode from the current index and shadow copy; registered one clock later.
  always_comb begin
    data_shift = data_s_q >> {idx_q, 2'b00};
    nib        = data_shift[3:0];
    onehot     = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;
`ifdef SEG_LZB_EN
    visible    = en_s_q[idx_q] && ((idx_q <= msd_idx) || (idx_q == '0));
`else
    visible    = en_s_q[idx_q];
`endif
    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (visible) begin
      an_d  = ~onehot;
      seg_d = hex7(nib);
      dp_d  = ~dp_s_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_clk_q    <= 1'b0;
      idx_q        <= IDX_W'(LAST_IDX);
      data_s_q     <= '0;
      dp_s_q       <= '0;
      en_s_q       <= '0;
      an_q         <= '1;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      led_clk_q    <= led_clk;
      idx_q        <= idx_d;
      frame_done_q <= wrap;
      if (wrap) begin
        data_s_q <= data_in;
        dp_s_q   <= dp_in;
        en_s_q   <= en_in;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led_scan.sv
// Directed, table-driven bench for led_scan (8 digits); expectations follow SEG_LZB_EN when defined.
module tb_led_scan;

  logic        clk = 1'b0;
  logic        reset, led_clk;
  logic [31:0] data_in;
  logic [7:0]  dp_in, en_in;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp, frame_done;

`ifdef SEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  led_scan #(.NUM_DIGITS(8)) dut (
    .clk(clk), .reset(reset), .led_clk(led_clk), .data_in(data_in),
    .dp_in(dp_in), .en_in(en_in), .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  en;
    logic [7:0]  dpi;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        fd;
  } vec_t;

  vec_t       tbl[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] prev_an;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] d, input logic [7:0] e, input logic [7:0] p,
                     input logic [7:0] a, input logic [6:0] s, input logic o, input logic f);
    vec_t v;
    v.data = d; v.en = e; v.dpi = p; v.an = a; v.seg = s; v.dp = o; v.fd = f;
    tbl.push_back(v);
  endtask

  // One led_clk pulse: after E0 pins still hold the previous digit, after E1 they show the new one.
  task automatic apply(input vec_t v, input string tag);
    data_in = v.data; en_in = v.en; dp_in = v.dpi;
    led_clk = 1'b1;
    step();
    chk({tag, " an_hold"}, an, prev_an);
    chk({tag, " frame_done"}, frame_done, v.fd);
    led_clk = 1'b0;
    step();
    chk({tag, " an"}, an, v.an);
    chk({tag, " seg"}, seg, v.seg);
    chk({tag, " dp"}, dp, v.dp);
    chk({tag, " fd_clear"}, frame_done, 1'b0);
    prev_an = v.an;
  endtask

  initial begin
    logic [7:0] an_exp [8];
    logic [6:0] seg_cnt [8];
    vec_t       v;
    int         fd_cnt;
    an_exp  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    seg_cnt = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

    // Frame A: counting digits; data flips to all-F while idx=3, must not show until wrap.
    add(32'h76543210, 8'hFF, 8'h00, 8'hFE, 7'h40, 1'b1, 1'b1);
    add(32'h76543210, 8'hFF, 8'h00, 8'hFD, 7'h79, 1'b1, 1'b0);
    add(32'h76543210, 8'hFF, 8'h00, 8'hFB, 7'h24, 1'b1, 1'b0);
    add(32'h76543210, 8'hFF, 8'h00, 8'hF7, 7'h30, 1'b1, 1'b0);
    add(32'hFFFFFFFF, 8'hFF, 8'h00, 8'hEF, 7'h19, 1'b1, 1'b0);
    add(32'hFFFFFFFF, 8'hFF, 8'h00, 8'hDF, 7'h12, 1'b1, 1'b0);
    add(32'hFFFFFFFF, 8'hFF, 8'h00, 8'hBF, 7'h02, 1'b1, 1'b0);
    add(32'hFFFFFFFF, 8'hFF, 8'h00, 8'h7F, 7'h78, 1'b1, 1'b0);
    // Frame B: all F; the en/dp change from pulse 10 on stays invisible until the next wrap.
    add(32'hFFFFFFFF, 8'hFF, 8'h00, 8'hFE, 7'h0E, 1'b1, 1'b1);
    add(32'h76543210, 8'h0F, 8'h01, 8'hFD, 7'h0E, 1'b1, 1'b0);
    add(32'h76543210, 8'h0F, 8'h01, 8'hFB, 7'h0E, 1'b1, 1'b0);
    add(32'h76543210, 8'h0F, 8'h01, 8'hF7, 7'h0E, 1'b1, 1'b0);
    add(32'h76543210, 8'h0F, 8'h01, 8'hEF, 7'h0E, 1'b1, 1'b0);
    add(32'h76543210, 8'h0F, 8'h01, 8'hDF, 7'h0E, 1'b1, 1'b0);
    add(32'h76543210, 8'h0F, 8'h01, 8'hBF, 7'h0E, 1'b1, 1'b0);
    add(32'h76543210, 8'h0F, 8'h01, 8'h7F, 7'h0E, 1'b1, 1'b0);
    // Frame C: en=0F, dp=01.
    add(32'h76543210, 8'h0F, 8'h01, 8'hFE, 7'h40, 1'b0, 1'b1);
    add(32'h76543210, 8'h0F, 8'h01, 8'hFD, 7'h79, 1'b1, 1'b0);
    add(32'h76543210, 8'h0F, 8'h01, 8'hFB, 7'h24, 1'b1, 1'b0);
    add(32'h76543210, 8'h0F, 8'h01, 8'hF7, 7'h30, 1'b1, 1'b0);
    for (int k = 4; k < 8; k++) add(32'h76543210, 8'h0F, 8'h01, 8'hFF, 7'h7F, 1'b1, 1'b0);
    // Frame D: 00000A05, leading zeros on digits 3..7.
    add(32'h00000A05, 8'hFF, 8'h00, 8'hFE, 7'h12, 1'b1, 1'b1);
    add(32'h00000A05, 8'hFF, 8'h00, 8'hFD, 7'h40, 1'b1, 1'b0);
    add(32'h00000A05, 8'hFF, 8'h00, 8'hFB, 7'h08, 1'b1, 1'b0);
    for (int k = 3; k < 8; k++)
      add(32'h00000A05, 8'hFF, 8'h00, LZB ? 8'hFF : an_exp[k], LZB ? 7'h7F : 7'h40, 1'b1, 1'b0);
    // Frame E: all zero with every dp requested; under LZB only digit 0 stays lit.
    add(32'h00000000, 8'hFF, 8'hFF, 8'hFE, 7'h40, 1'b0, 1'b1);
    for (int k = 1; k < 8; k++)
      add(32'h00000000, 8'hFF, 8'hFF, LZB ? 8'hFF : an_exp[k], LZB ? 7'h7F : 7'h40, LZB, 1'b0);

    // Reset held 3 clocks with led_clk low.
    reset = 1'b1; led_clk = 1'b0; data_in = '0; dp_in = '0; en_in = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst an", an, 8'hFF);
      chk("rst seg", seg, 7'h7F);
      chk("rst dp", dp, 1'b1);
      chk("rst fd", frame_done, 1'b0);
    end
    reset = 1'b0;
    step(); step();
    chk("idle an", an, 8'hFF);
    chk("idle seg", seg, 7'h7F);
    prev_an = 8'hFF;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // led_clk held high for 1000 clocks: exactly one advance (wrap from 7 to 0).
    data_in = 32'h76543210; en_in = 8'hFF; dp_in = 8'h00;
    led_clk = 1'b1;
    fd_cnt = 0;
    for (int c = 0; c < 1000; c++) begin
      step();
      if (frame_done === 1'b1) fd_cnt++;
    end
    led_clk = 1'b0;
    step(); step(); step();
    chk("hold fd_count", fd_cnt, 1);
    chk("hold an", an, 8'hFE);
    chk("hold seg", seg, 7'h40);
    prev_an = 8'hFE;
    for (int k = 1; k < 8; k++) begin
      v.data = 32'h76543210; v.en = 8'hFF; v.dpi = 8'h00;
      v.an = an_exp[k]; v.seg = seg_cnt[k]; v.dp = 1'b1; v.fd = 1'b0;
      apply(v, $sformatf("post_hold%0d", k));
    end

    // Reset in the same clock as a wrapping tick: reset wins, no frame_done.
    reset = 1'b1; led_clk = 1'b1;
    step();
    chk("rst_tick an", an, 8'hFF);
    chk("rst_tick seg", seg, 7'h7F);
    chk("rst_tick dp", dp, 1'b1);
    chk("rst_tick fd", frame_done, 1'b0);
    reset = 1'b0; led_clk = 1'b0;
    step(); step(); step();
    chk("post_rst an", an, 8'hFF);
    chk("post_rst fd", frame_done, 1'b0);
    prev_an = 8'hFF;
    v.data = 32'h76543210; v.en = 8'hFF; v.dpi = 8'h00;
    v.an = 8'hFE; v.seg = 7'h40; v.dp = 1'b1; v.fd = 1'b1;
    apply(v, "first_tick");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
